// File: rtl/operand_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : operand_mem_pkg
// Purpose : Shared defaults and clear-engine state type for the operand pair
//           store (operand_pair_ram / opmem_bank).
// Contents: c_DEF_DATA_W, c_DEF_ADDR_W - default operand width / address width
//           clr_state_t                - clear engine states (ST_IDLE, ST_CLEAR)
// Revision: 1.0 - initial release
// ============================================================================
package operand_mem_pkg;

    localparam int c_DEF_DATA_W = 64;
    localparam int c_DEF_ADDR_W = 6;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_t;

endpackage
`default_nettype wire

// File: rtl/opmem_bank.sv
`default_nettype none
// ============================================================================
// Module  : opmem_bank
// Purpose : One operand bank: single write port, single registered read port,
//           selectable same-address read/write ordering.
// Ports   : clk, rst_n          - clock, asynchronous active-low reset
//           i_we/i_waddr/i_wdata - write strobe, address, data
//           i_re/i_raddr         - read enable (loads output register), address
//           o_rdata              - registered read data (holds when i_re low)
// Revision: 1.0 - initial release
// ============================================================================
module opmem_bank
    import operand_mem_pkg::*;
#(
    parameter int DATA_W   = c_DEF_DATA_W,
    parameter int ADDR_W   = c_DEF_ADDR_W,
    parameter int RW_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int c_DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [c_DEPTH];
    logic [DATA_W-1:0] r_rdata;
    logic              w_bypass;

    // Write-first returns the word being written this edge; read-first simply
    // sees the array before the non-blocking write lands.
    generate
        if (RW_FIRST != 0) begin : g_write_first
            assign w_bypass = i_we && (i_waddr == i_raddr);
        end else begin : g_read_first
            assign w_bypass = 1'b0;
        end
    endgenerate

    // Storage is deliberately left out of reset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= w_bypass ? i_wdata : r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/operand_pair_ram.sv
`default_nettype none
// ============================================================================
// Module  : operand_pair_ram
// Purpose : Two-bank operand store (A/B) with registered reads, valid flag and
//           a sequential clear engine that zeroes both banks.
// Ports   : mem_clk, mem_rst_n            - clock, async active-low reset
//           wr_en/addr/data_opa|opb       - independent bank writes
//           rd_req, rd_addr_opa|opb       - joint read request, per-bank address
//           rd_valid, rd_data_opa|opb     - read result, one cycle after rd_req
//           clr_start, clr_busy           - clear pulse, clear engine active
// Revision: 1.0 - initial release
// ============================================================================
module operand_pair_ram
    import operand_mem_pkg::*;
#(
    parameter int DATA_W   = c_DEF_DATA_W,
    parameter int ADDR_W   = c_DEF_ADDR_W,
    parameter int RW_FIRST = 1
) (
    input  logic              mem_clk,
    input  logic              mem_rst_n,
    input  logic              wr_en_opa,
    input  logic [ADDR_W-1:0] wr_addr_opa,
    input  logic [DATA_W-1:0] wr_data_opa,
    input  logic              wr_en_opb,
    input  logic [ADDR_W-1:0] wr_addr_opb,
    input  logic [DATA_W-1:0] wr_data_opb,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr_opa,
    input  logic [ADDR_W-1:0] rd_addr_opb,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data_opa,
    output logic [DATA_W-1:0] rd_data_opb,
    input  logic              clr_start,
    output logic              clr_busy
);

    // Counter is one bit wider than the address so the terminal compare
    // never aliases with a wrapped value.
    localparam logic [ADDR_W:0] c_CNT_LAST = (ADDR_W+1)'((1 << ADDR_W) - 1);

    clr_state_t        r_state;
    clr_state_t        w_state_nxt;
    logic [ADDR_W:0]   r_clr_cnt;
    logic [ADDR_W:0]   w_clr_cnt_nxt;
    logic              r_rd_valid;

    logic              w_clearing;
    logic              w_re;
    logic              w_we_a;
    logic              w_we_b;
    logic [ADDR_W-1:0] w_waddr_a;
    logic [ADDR_W-1:0] w_waddr_b;
    logic [DATA_W-1:0] w_wdata_a;
    logic [DATA_W-1:0] w_wdata_b;

    always_ff @(posedge mem_clk or negedge mem_rst_n) begin
        if (!mem_rst_n) begin
            r_state    <= ST_IDLE;
            r_clr_cnt  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_cnt  <= w_clr_cnt_nxt;
            r_rd_valid <= w_re;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        w_clearing    = 1'b0;
        w_re          = 1'b0;
        w_we_a        = 1'b0;
        w_we_b        = 1'b0;
        w_waddr_a     = wr_addr_opa;
        w_waddr_b     = wr_addr_opb;
        w_wdata_a     = wr_data_opa;
        w_wdata_b     = wr_data_opb;

        case (r_state)
            ST_IDLE: begin
                // A read coinciding with clr_start still completes; a write
                // coinciding with it is dropped because the clear wins.
                w_re   = rd_req;
                w_we_a = wr_en_opa && !clr_start;
                w_we_b = wr_en_opb && !clr_start;
                if (clr_start) begin
                    w_state_nxt   = ST_CLEAR;
                    w_clr_cnt_nxt = '0;
                end
            end
            ST_CLEAR: begin
                // External traffic is ignored; both banks take the zero word.
                w_clearing = 1'b1;
                w_we_a     = 1'b1;
                w_we_b     = 1'b1;
                w_waddr_a  = r_clr_cnt[ADDR_W-1:0];
                w_waddr_b  = r_clr_cnt[ADDR_W-1:0];
                w_wdata_a  = '0;
                w_wdata_b  = '0;
                if (r_clr_cnt == c_CNT_LAST) begin
                    w_state_nxt   = ST_IDLE;
                    w_clr_cnt_nxt = '0;
                end else begin
                    w_clr_cnt_nxt = r_clr_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_clr_cnt_nxt = '0;
            end
        endcase
    end

    opmem_bank #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .RW_FIRST (RW_FIRST)
    ) u_bank_a (
        .clk     (mem_clk),
        .rst_n   (mem_rst_n),
        .i_we    (w_we_a),
        .i_waddr (w_waddr_a),
        .i_wdata (w_wdata_a),
        .i_re    (w_re),
        .i_raddr (rd_addr_opa),
        .o_rdata (rd_data_opa)
    );

    opmem_bank #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .RW_FIRST (RW_FIRST)
    ) u_bank_b (
        .clk     (mem_clk),
        .rst_n   (mem_rst_n),
        .i_we    (w_we_b),
        .i_waddr (w_waddr_b),
        .i_wdata (w_wdata_b),
        .i_re    (w_re),
        .i_raddr (rd_addr_opb),
        .o_rdata (rd_data_opb)
    );

    assign rd_valid = r_rd_valid;
    assign clr_busy = w_clearing;

endmodule
`default_nettype wire
